// File: rtl/isw_pkg.sv
// -----------------------------------------------------------------------------
// isw_pkg
// Shared definitions for the ISW share encoder slice.
//   state_t        : encoder window FSM states
//   GADGET_LAT     : cycles from gadget inputs to valid gadget output shares
//   FIELD_*        : positions of the fields inside the randomness word,
//                    counted in units of the datapath width
//   rnd_lo()       : low bit index of a randomness field for a given width
// -----------------------------------------------------------------------------
package isw_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD1 = 2'd2,
      HOLD2 = 2'd3
   } state_t;

   // The gadget output is valid GADGET_LAT cycles after its inputs first
   // appear. Inputs are held for GADGET_LAT + 1 cycles (ISSUE, HOLD1, HOLD2),
   // so the capture happens at the end of HOLD2.
   localparam int GADGET_LAT = 2;

   // rnd_i layout: {R01, mB, mA}
   localparam int FIELD_MA  = 0;
   localparam int FIELD_MB  = 1;
   localparam int FIELD_R01 = 2;

   function automatic int rnd_lo(input int field, input int width);
      return field * width;
   endfunction

endpackage

// File: rtl/isw_share_split.sv
// -----------------------------------------------------------------------------
// isw_share_split
// Registered 2-share Boolean splitter for one operand. Only the masked value
// data^mask and the mask itself are stored; the plaintext never lands in a
// register.
//   clk    : clock
//   rst    : synchronous active-high reset, clears both shares
//   load   : capture data^mask / mask this edge
//   clear  : zero both shares this edge (window closing)
//   data   : plaintext operand
//   mask   : fresh mask
//   share0 : data ^ mask
//   share1 : mask
// -----------------------------------------------------------------------------
module isw_share_split #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] data,
   input  logic [WIDTH-1:0] mask,
   output logic [WIDTH-1:0] share0,
   output logic [WIDTH-1:0] share1
);

   always_ff @(posedge clk) begin
      if (rst) begin
         share0 <= '0;
         share1 <= '0;
      end else if (load) begin
         // load wins over clear: a HOLD2 accept starts a new window
         share0 <= data ^ mask;
         share1 <= mask;
      end else if (clear) begin
         share0 <= '0;
         share1 <= '0;
      end
   end

endmodule

// File: rtl/isw_share_encoder.sv
// -----------------------------------------------------------------------------
// isw_share_encoder
// Masks two plaintext operands into Boolean shares for a first-order 2-share
// ISW AND gadget, holds the gadget inputs for its 3-cycle window, and
// recombines the gadget output shares into a registered plaintext result.
//
// Handshake: an operand pair (in_valid_i/in_ready_o) and a randomness word
// (rnd_valid_i/rnd_ready_o) transfer together on a rising edge where
// in_valid_i & rnd_valid_i & (state is IDLE or HOLD2). Each ready depends only
// on the other side's valid and on state, never on its own valid, so neither
// side sees a combinational loop; a producer with valid high must hold its
// data until the transfer edge.
//
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   in_valid_i/in_ready_o   : operand handshake
//   A_i, B_i                : plaintext operands
//   rnd_valid_i/rnd_ready_o : randomness handshake
//   rnd_i                   : {R01, mB, mA}
//   X0_o, X1_o, Y0_o, Y1_o  : shares of A and B to the gadget
//   R01_o                   : gadget refresh randomness
//   issue_o                 : first cycle of a gadget window
//   Q0_i, Q1_i              : gadget output shares
//   res_valid_o, res_o      : one-cycle unmasked result A&B
//   stall_cnt_o             : saturating count of randomness-starved cycles
//   state_o                 : FSM state (debug)
// -----------------------------------------------------------------------------
module isw_share_encoder
   import isw_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int STALL_W = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [WIDTH-1:0]   A_i,
   input  logic [WIDTH-1:0]   B_i,
   input  logic               rnd_valid_i,
   output logic               rnd_ready_o,
   input  logic [3*WIDTH-1:0] rnd_i,
   output logic [WIDTH-1:0]   X0_o,
   output logic [WIDTH-1:0]   X1_o,
   output logic [WIDTH-1:0]   Y0_o,
   output logic [WIDTH-1:0]   Y1_o,
   output logic [WIDTH-1:0]   R01_o,
   output logic               issue_o,
   input  logic [WIDTH-1:0]   Q0_i,
   input  logic [WIDTH-1:0]   Q1_i,
   output logic               res_valid_o,
   output logic [WIDTH-1:0]   res_o,
   output logic [STALL_W-1:0] stall_cnt_o,
   output state_t             state_o
);

   localparam int MA_LO  = rnd_lo(FIELD_MA, WIDTH);
   localparam int MB_LO  = rnd_lo(FIELD_MB, WIDTH);
   localparam int R01_LO = rnd_lo(FIELD_R01, WIDTH);

   state_t           state;
   state_t           state_nxt;
   logic             slot_open;
   logic             acc;
   logic             starve;
   logic             clear;
   logic [WIDTH-1:0] mask_a;
   logic [WIDTH-1:0] mask_b;
   logic [WIDTH-1:0] r01_field;

   assign mask_a    = rnd_i[MA_LO +: WIDTH];
   assign mask_b    = rnd_i[MB_LO +: WIDTH];
   assign r01_field = rnd_i[R01_LO +: WIDTH];

   // A new window may start only when the previous one is idle or in its last
   // cycle, which gives the one-op-per-3-cycles back-to-back rate.
   assign slot_open = (state == IDLE) || (state == HOLD2);
   assign acc       = in_valid_i & rnd_valid_i & slot_open;
   assign starve    = in_valid_i & ~rnd_valid_i & slot_open;

   // Readies are forced low while reset is asserted, whatever the state.
   assign in_ready_o  = rnd_valid_i & slot_open & ~rst_i;
   assign rnd_ready_o = in_valid_i & slot_open & ~rst_i;

   assign state_o = state;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (acc) state_nxt = ISSUE;
         ISSUE:   state_nxt = HOLD1;
         HOLD1:   state_nxt = HOLD2;
         HOLD2:   state_nxt = acc ? ISSUE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Shares are wiped when the window closes so stale masked data does not
   // linger on the gadget inputs.
   assign clear = (state != IDLE) && (state_nxt == IDLE);

   // ------------------------------------------------------- share front end
   isw_share_split #(.WIDTH(WIDTH)) u_split_a (
      .clk    (clk_i),
      .rst    (rst_i),
      .load   (acc),
      .clear  (clear),
      .data   (A_i),
      .mask   (mask_a),
      .share0 (X0_o),
      .share1 (X1_o)
   );

   isw_share_split #(.WIDTH(WIDTH)) u_split_b (
      .clk    (clk_i),
      .rst    (rst_i),
      .load   (acc),
      .clear  (clear),
      .data   (B_i),
      .mask   (mask_b),
      .share0 (Y0_o),
      .share1 (Y1_o)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         R01_o <= '0;
      end else if (acc) begin
         R01_o <= r01_field;
      end else if (clear) begin
         R01_o <= '0;
      end
   end

   // issue_o is registered from the next state so it equals (state == ISSUE).
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         issue_o <= 1'b0;
      end else begin
         issue_o <= (state_nxt == ISSUE);
      end
   end

   // ------------------------------------------------------ decoder back end
   // Gadget output is valid during HOLD2; capture it on the edge leaving HOLD2.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         res_valid_o <= 1'b0;
         res_o       <= '0;
      end else begin
         res_valid_o <= (state == HOLD2);
         if (state == HOLD2) begin
            res_o <= Q0_i ^ Q1_i;
         end
      end
   end

   // ------------------------------------------------- starvation counter
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_o <= '0;
      end else if (starve && (stall_cnt_o != {STALL_W{1'b1}})) begin
         stall_cnt_o <= stall_cnt_o + STALL_W'(1);
      end
   end

endmodule

// File: tb/tb_isw_share_encoder.sv
// -----------------------------------------------------------------------------
// tb_isw_share_encoder
// Bench for isw_share_encoder. A behavioural 2-stage ISW AND gadget with a
// random output re-mask drives Q0/Q1. A monitor pushes A&B into exp_q at every
// transfer and pops it on each res_valid_o. A second instance with STALL_W=4
// shares all inputs and is used for the saturation check.
// -----------------------------------------------------------------------------
module tb_isw_share_encoder;
   import isw_pkg::*;

   localparam int W = 8;

   // ------------------------------------------------ clock / reset block
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ------------------------------------------------------------ signals
   logic           in_valid, rnd_valid;
   logic [W-1:0]   a, b;
   logic [3*W-1:0] rnd;
   logic [W-1:0]   q0, q1;

   logic           in_ready, rnd_ready, issue, res_valid;
   logic [W-1:0]   x0, x1, y0, y1, r01, res;
   logic [15:0]    stall_cnt;
   state_t         state;

   logic           s_in_ready, s_rnd_ready, s_issue, s_res_valid;
   logic [W-1:0]   s_x0, s_x1, s_y0, s_y1, s_r01, s_res;
   logic [3:0]     s_stall_cnt;
   state_t         s_state;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [W-1:0]   exp_q[$];
   logic [2*W-1:0] op_q[$];

   isw_share_encoder #(.WIDTH(W), .STALL_W(16)) dut (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .A_i(a), .B_i(b),
      .rnd_valid_i(rnd_valid), .rnd_ready_o(rnd_ready), .rnd_i(rnd),
      .X0_o(x0), .X1_o(x1), .Y0_o(y0), .Y1_o(y1), .R01_o(r01),
      .issue_o(issue), .Q0_i(q0), .Q1_i(q1),
      .res_valid_o(res_valid), .res_o(res),
      .stall_cnt_o(stall_cnt), .state_o(state)
   );

   isw_share_encoder #(.WIDTH(W), .STALL_W(4)) dut_sat (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid), .in_ready_o(s_in_ready),
      .A_i(a), .B_i(b),
      .rnd_valid_i(rnd_valid), .rnd_ready_o(s_rnd_ready), .rnd_i(rnd),
      .X0_o(s_x0), .X1_o(s_x1), .Y0_o(s_y0), .Y1_o(s_y1), .R01_o(s_r01),
      .issue_o(s_issue), .Q0_i(q0), .Q1_i(q1),
      .res_valid_o(s_res_valid), .res_o(s_res),
      .stall_cnt_o(s_stall_cnt), .state_o(s_state)
   );

   // ----------------------------------------------- gadget model (2 stages)
   logic [W-1:0] g_q0, g_q1, g_z;
   always @(posedge clk) begin
      g_z   = W'($urandom);
      g_q0 <= (x0 & y0) ^ r01 ^ g_z;
      g_q1 <= (x1 & y1) ^ (r01 ^ (x0 & y1)) ^ (x1 & y0) ^ g_z;
      q0   <= g_q0;
      q1   <= g_q1;
   end

   // --------------------------------------------------- scoreboard monitor
   logic [W-1:0] mon_a, mon_b, mon_r;
   always @(negedge clk) begin
      if (!rst) begin
         if (in_valid && rnd_valid) begin
            tests_run++;
            if (rnd_ready !== in_ready) begin
               tests_failed++;
               $display("FAIL ready_pair: rnd_ready=%b in_ready=%b", rnd_ready, in_ready);
            end
         end
         if (in_valid && rnd_valid && in_ready === 1'b1) begin
            exp_q.push_back(a & b);
            op_q.push_back({a, b});
         end
         if (issue === 1'b1) begin
            tests_run++;
            if (op_q.size() == 0) begin
               tests_failed++;
               $display("FAIL issue_unexpected: issue_o=1 with no pending op");
            end else begin
               {mon_a, mon_b} = op_q.pop_front();
               if ((x0 ^ x1) !== mon_a || (y0 ^ y1) !== mon_b) begin
                  tests_failed++;
                  $display("FAIL share_recombine: X0^X1=%h Y0^Y1=%h required %h %h",
                           x0 ^ x1, y0 ^ y1, mon_a, mon_b);
               end
            end
         end
         if (res_valid === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("FAIL res_unexpected: res_valid_o=1 res_o=%h with nothing pending", res);
            end else begin
               mon_r = exp_q.pop_front();
               if (res !== mon_r) begin
                  tests_failed++;
                  $display("FAIL res_value: res_o=%h required %h", res, mon_r);
               end
            end
         end
      end
   end

   // ------------------------------------------------------- driver tasks
   task automatic drive_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic [W-1:0] ma, input logic [W-1:0] mb,
                           input logic [W-1:0] rv);
      a         = av;
      b         = bv;
      rnd       = {rv, mb, ma};
      in_valid  = 1'b1;
      rnd_valid = 1'b1;
   endtask

   // Returns #1 after the transfer edge, valids still asserted.
   task automatic wait_accept();
      bit ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("FAIL accept_timeout: in_ready_o=%b after 30 cycles, required 1", in_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ma, input logic [W-1:0] mb,
                          input logic [W-1:0] rv);
      drive_op(av, bv, ma, mb, rv);
      wait_accept();
   endtask

   task automatic wait_drain();
      bit ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && op_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("FAIL drain_timeout: %0d results still pending, required 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      rnd_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      op_q.delete();
   endtask

   // -------------------------------------------------------------- tests
   task automatic test_reset();
      // valids high during reset: readies must still be low
      rst       = 1'b1;
      in_valid  = 1'b1;
      rnd_valid = 1'b1;
      a         = 8'h00;
      b         = 8'h00;
      rnd       = '0;
      @(posedge clk);
      #1;
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b0 || rnd_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_ready: in_ready=%b rnd_ready=%b required 0 0", in_ready, rnd_ready);
      end
      tests_run++;
      if (state !== IDLE || issue !== 1'b0 || res_valid !== 1'b0 || stall_cnt !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: state=%0d issue=%b res_valid=%b stall=%0d required 0 0 0 0",
                  state, issue, res_valid, stall_cnt);
      end
      tests_run++;
      if ({x0, x1, y0, y1, r01, res} !== 48'd0) begin
         tests_failed++;
         $display("FAIL reset_data: shares/res=%h required 0", {x0, x1, y0, y1, r01, res});
      end
      in_valid  = 1'b0;
      rnd_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_single_op();
      drive_op(8'hF0, 8'h3C, 8'h5A, 8'hA5, 8'h11);
      @(negedge clk);                       // accept cycle t
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL single_ready: in_ready=%b required 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      rnd_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin    // cycles t+1 .. t+3
         @(negedge clk);
         tests_run++;
         if ({x0, x1, y0, y1, r01} !== 40'hAA5A99A511 || issue !== (c == 1) || res_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_hold%0d: shares=%h issue=%b res_valid=%b required AA5A99A511 %b 0",
                     c, {x0, x1, y0, y1, r01}, issue, res_valid, (c == 1));
         end
      end
      @(negedge clk);                       // cycle t+4
      tests_run++;
      if (res_valid !== 1'b1 || res !== 8'h30) begin
         tests_failed++;
         $display("FAIL single_result: res_valid=%b res=%h required 1 30", res_valid, res);
      end
      @(negedge clk);                       // cycle t+5
      tests_run++;
      if (res_valid !== 1'b0 || {x0, x1, y0, y1, r01} !== 40'd0 || state !== IDLE) begin
         tests_failed++;
         $display("FAIL single_after: res_valid=%b shares=%h state=%0d required 0 0 0",
                  res_valid, {x0, x1, y0, y1, r01}, state);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         drive_op(W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
         @(negedge clk);                    // IDLE or HOLD2
         tests_run++;
         if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_open%0d: in_ready=%b required 1", i, in_ready);
         end
         @(posedge clk);
         #1;
         if (i == 3) begin
            in_valid  = 1'b0;
            rnd_valid = 1'b0;
         end
         @(negedge clk);                    // ISSUE
         tests_run++;
         if (issue !== 1'b1 || (i < 3 && in_ready !== 1'b0)) begin
            tests_failed++;
            $display("FAIL b2b_issue%0d: issue=%b in_ready=%b required 1 0", i, issue, in_ready);
         end
         @(negedge clk);                    // HOLD1
         tests_run++;
         if (issue !== 1'b0 || (i < 3 && in_ready !== 1'b0)) begin
            tests_failed++;
            $display("FAIL b2b_hold%0d: issue=%b in_ready=%b required 0 0", i, issue, in_ready);
         end
         if (i < 3) begin
            @(posedge clk);
            #1;
         end
      end
      wait_drain();
   endtask

   task automatic test_starvation();
      do_reset();
      a         = 8'h96;
      b         = 8'h7E;
      in_valid  = 1'b1;
      rnd_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b0 || exp_q.size() != 0 || stall_cnt !== 16'd5) begin
         tests_failed++;
         $display("FAIL starve_mid: in_ready=%b accepted=%0d stall=%0d required 0 0 5",
                  in_ready, exp_q.size(), stall_cnt);
      end
      repeat (5) @(posedge clk);
      #1;
      drive_op(8'h96, 8'h7E, 8'h33, 8'hC4, 8'h0F);
      @(negedge clk);
      tests_run++;
      if (stall_cnt !== 16'd10 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL starve_count: stall=%0d in_ready=%b required 10 1", stall_cnt, in_ready);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      rnd_valid = 1'b0;
      @(negedge clk);
      tests_run++;
      if (stall_cnt !== 16'd10 || issue !== 1'b1) begin
         tests_failed++;
         $display("FAIL starve_after: stall=%0d issue=%b required 10 1", stall_cnt, issue);
      end
      wait_drain();
   endtask

   task automatic test_saturation();
      do_reset();
      in_valid  = 1'b1;
      rnd_valid = 1'b0;
      repeat (14) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (s_stall_cnt !== 4'd14 || stall_cnt !== 16'd14) begin
         tests_failed++;
         $display("FAIL sat_14: narrow=%0d wide=%0d required 14 14", s_stall_cnt, stall_cnt);
      end
      repeat (6) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (s_stall_cnt !== 4'd15 || stall_cnt !== 16'd20) begin
         tests_failed++;
         $display("FAIL sat_20: narrow=%0d wide=%0d required 15 20", s_stall_cnt, stall_cnt);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset_mid_window();
      do_reset();
      send_op(8'hC3, 8'hFF, 8'h81, 8'h18, 8'h42);   // now in ISSUE
      in_valid  = 1'b0;
      rnd_valid = 1'b0;
      @(posedge clk);
      #1;                                            // now in HOLD1
      rst = 1'b1;
      exp_q.delete();
      op_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (state !== IDLE || issue !== 1'b0 || res_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstmid_ctrl: state=%0d issue=%b res_valid=%b required 0 0 0",
                  state, issue, res_valid);
      end
      tests_run++;
      if ({x0, x1, y0, y1, r01} !== 40'd0) begin
         tests_failed++;
         $display("FAIL rstmid_shares: shares=%h required 0", {x0, x1, y0, y1, r01});
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         tests_run++;
         if (res_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_nores%0d: res_valid=%b required 0", c, res_valid);
         end
      end
      @(posedge clk);
      #1;
      send_op(8'h5C, 8'h3A, 8'hE7, 8'h19, 8'h6D);
      in_valid  = 1'b0;
      rnd_valid = 1'b0;
      wait_drain();
   endtask

   task automatic test_random();
      int gap;
      int starve;
      do_reset();
      for (int n = 0; n < 1000; n++) begin
         gap = $urandom_range(0, 3);
         if (gap != 0) begin
            in_valid  = 1'b0;
            rnd_valid = 1'b0;
            repeat (gap) begin
               @(posedge clk);
               #1;
            end
         end
         starve = $urandom_range(0, 2);
         if (starve != 0) begin
            a         = W'($urandom);
            b         = W'($urandom);
            in_valid  = 1'b1;
            rnd_valid = 1'b0;
            repeat (starve) begin
               @(posedge clk);
               #1;
            end
         end
         send_op(W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
      end
      in_valid  = 1'b0;
      rnd_valid = 1'b0;
      wait_drain();
   endtask

   // ------------------------------------------------------------ sequence
   initial begin
      test_reset();
      test_single_op();
      test_back_to_back();
      test_starvation();
      test_saturation();
      test_reset_mid_window();
      test_random();
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL final_queue: %0d results pending, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
